// File: rtl/riscv_branch_resolve_unit.sv
// Branch resolve unit: tracks fetch-stage predictions in order, checks them against
// EX outcomes, trains the predictor, and raises a held redirect on a misprediction.
module riscv_branch_resolve_unit #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned Q_DEPTH = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_push,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             pred_full,
  input  logic             ex_br_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             branch_resolved,
  output logic [XLEN-1:0]  branch_pc,
  output logic             branch_actual,
  output logic [XLEN-1:0]  branch_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  q_pc     [Q_DEPTH];
  logic             q_taken  [Q_DEPTH];
  logic [XLEN-1:0]  q_target [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic             q_empty;
  logic             resolve_acc;
  logic             push_acc;
  logic             pop_acc;
  logic             mispredict;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  correct_pc;
  logic [XLEN-1:0]  head_pc;
  logic             head_taken;
  logic [XLEN-1:0]  head_target;

  assign q_empty   = (occ == '0);
  assign pred_full = (occ == OCC_W'(Q_DEPTH));

  // An empty queue falls back to a static not-taken prediction for the resolving branch.
  always_comb begin
    pc_plus4    = ex_pc + XLEN'(4);
    correct_pc  = ex_taken ? ex_target : pc_plus4;
    head_pc     = ex_pc;
    head_taken  = 1'b0;
    head_target = pc_plus4;
    if (!q_empty) begin
      head_pc     = q_pc[rd_ptr];
      head_taken  = q_taken[rd_ptr];
      head_target = q_target[rd_ptr];
    end
    resolve_acc = (state == IDLE) && ex_br_valid;
    mispredict  = resolve_acc &&
                  ((head_pc != ex_pc) || (head_taken != ex_taken) ||
                   (ex_taken && (head_target != ex_target)));
    pop_acc     = resolve_acc && !q_empty;
    // A full queue still takes a push when the same cycle frees the head slot.
    push_acc    = (state == IDLE) && pred_push && !mispredict && (!pred_full || pop_acc);
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      q_pc[wr_ptr]     <= pred_pc;
      q_taken[wr_ptr]  <= pred_taken;
      q_target[wr_ptr] <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      branch_resolved  <= 1'b0;
      branch_pc        <= '0;
      branch_actual    <= 1'b0;
      branch_target    <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      branch_resolved <= resolve_acc;
      if (resolve_acc) begin
        branch_pc     <= ex_pc;
        branch_actual <= ex_taken;
        branch_target <= ex_target;
        if (branch_count != '1) branch_count <= branch_count + 1'b1;
      end
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 1'b1;

      case (state)
        IDLE: begin
          if (mispredict) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            redirect_pc    <= correct_pc;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            if (push_acc && !pop_acc)      occ <= occ + 1'b1;
            else if (!push_acc && pop_acc) occ <= occ - 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_valid && redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_branch_resolve_unit.md
Name: riscv_branch_resolve_unit

Overview:
- Execute-side counterpart of the fetch-stage branch predictor.
- Records each prediction made at fetch in an in-order queue, compares it against the actual outcome when the branch resolves in EX, and returns the training packet (resolved/pc/actual/target) to the predictor.
- On a misprediction, flushes queued wrong-path predictions and holds a redirect request to fetch until it is accepted.
- Also keeps saturating branch and mispredict performance counters.

Parameters:
- XLEN, 64, address/PC width.
- Q_DEPTH, 4, number of in-flight predictions tracked; power of two, 2 or greater.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- pred_push  in  1  fetch recorded a prediction for a branch this cycle.
- pred_pc  in  XLEN  PC of the predicted branch.
- pred_taken  in  1  predicted direction.
- pred_target  in  XLEN  predicted next PC.
- pred_full  out  1  queue full; fetch must not push.
- ex_br_valid  in  1  a conditional branch resolved in EX this cycle.
- ex_pc  in  XLEN  PC of the resolved branch.
- ex_taken  in  1  actual direction.
- ex_target  in  XLEN  actual taken target.
- branch_resolved  out  1  one-cycle training pulse to the predictor.
- branch_pc  out  XLEN  resolved branch PC.
- branch_actual  out  1  actual direction.
- branch_target  out  XLEN  actual target.
- redirect_valid  out  1  fetch must restart at redirect_pc.
- redirect_pc  out  XLEN  corrected next PC.
- redirect_ready  in  1  fetch accepts the redirect.
- branch_count  out  CNT_W  resolved branches.
- mispredict_count  out  CNT_W  mispredictions.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values:
  - Queue empty; pred_full=0.
  - FSM in IDLE.
  - branch_resolved=0, branch_pc=0, branch_actual=0, branch_target=0.
  - redirect_valid=0, redirect_pc=0.
  - Both counters 0.
- Reset mid-redirect drops the pending redirect and empties the queue.
- Queue: in-order FIFO of {pc, taken, target}.
  - Write pointer advances on an accepted push; read pointer advances on an accepted resolve.
  - Pointers wrap modulo Q_DEPTH.
  - Occupancy counter width is log2(Q_DEPTH)+1; pred_full = (occupancy == Q_DEPTH).
  - A push while full is dropped and the queue is unchanged.
  - Push and resolve in the same cycle: both take effect and occupancy is unchanged, including when full.
- FSM states:
  - IDLE: pushes and resolves accepted.
  - REDIRECT: redirect_valid=1; pushes and ex_br_valid are dropped as wrong-path with no training, counting or queue change. Exit to IDLE on the cycle after redirect_valid & redirect_ready.
- Resolve in IDLE (ex_br_valid=1):
  - Pop the head. With the queue empty, use the default prediction {pc=ex_pc, taken=0, target=ex_pc+4}.
  - correct_pc = ex_taken ? ex_target : ex_pc+4, computed modulo 2^XLEN.
  - Mispredict when any of the following holds: head.pc != ex_pc (queue desync); head.taken != ex_taken; ex_taken and head.target != ex_target.
- Training latency:
  - branch_resolved pulses for exactly one cycle, in the cycle after a resolve accepted in IDLE.
  - branch_pc, branch_actual and branch_target are registered copies of ex_pc, ex_taken and ex_target, held until the next pulse.
- Mispredict:
  - On the detecting edge: queue cleared, with any same-cycle push dropped; redirect_pc <= correct_pc; FSM -> REDIRECT.
  - redirect_valid rises the next cycle, together with branch_resolved.
  - redirect_valid and redirect_pc are held stable until accepted.
  - There is no back-to-back redirect; the next resolve is accepted only once the FSM is back in IDLE.
- Counters:
  - branch_count increments on each accepted resolve.
  - mispredict_count increments on each detected mispredict.
  - Both saturate at all-ones, with no wrap.

Test Plan:
- Correct prediction: push {pc=0x1000, taken=1, target=0x1200}, then resolve ex_pc=0x1000, taken=1, target=0x1200 -> next cycle branch_resolved=1, branch_pc=0x1000, branch_actual=1; redirect_valid stays 0; branch_count=1, mispredict_count=0.
- Direction mispredict: push {0x2000, taken=0}; push {0x2010, taken=1, target=0x2100}; resolve 0x2000 taken=1 target=0x2400 -> redirect_valid=1 with redirect_pc=0x2400 the next cycle; queue empty; with redirect_ready held 0 for 3 cycles, redirect stays stable; when accepted, IDLE the next cycle; mispredict_count=1.
- Target mispredict plus wrong-path drop: push {0x3000, 1, 0x3100}; resolve taken=1 target=0x3200 -> redirect_pc=0x3200; an ex_br_valid during REDIRECT yields no branch_resolved pulse and branch_count stays 1.
- Not-taken correction and empty queue: resolve ex_pc=0x4000 taken=1 target=0x4800 with the queue empty -> mispredict, redirect_pc=0x4800. Separately, push {0x5000, 1, 0x5100} and resolve taken=0 -> redirect_pc=0x5004.
- Full and wrap: push 4 entries -> pred_full=1; a 5th push is dropped; simultaneous push and correct resolve keep pred_full=1; repeat 10 cycles so the pointers wrap; every resolve trains with the correct PC and no redirect occurs.
- Reset mid-redirect: assert rst while redirect_valid=1 -> the next cycle all outputs are 0, the queue is empty and the FSM is in IDLE.
